// File: rtl/sram_port_master_pkg.sv
// sram_port_master_pkg
//   Shared definitions for the SRAM port master slice: default bus widths,
//   the per-cycle SRAM operation encoding, the read pipeline depth and the
//   burst read FSM state codes (used only when SRAM_PORT_MASTER_BURST_EN
//   is defined).
package sram_port_master_pkg;

  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DATA_W = 16;

  // Cycles from read acceptance to the RRSP_VALID strobe.
  localparam int READ_LAT = 2;

  typedef enum logic [1:0] {
    OP_IDLE = 2'd0,
    OP_WR   = 2'd1,
    OP_RD   = 2'd2
  } op_e;

  localparam logic [0:0] RD_IDLE  = 1'b0;
  localparam logic [0:0] RD_BURST = 1'b1;

endpackage

// File: rtl/sram_port_master_if.sv
// sram_port_master_if
//   Bundles the request streams, the read response and the SRAM pins.
//   master modport : view of sram_port_master
//     in  WREQ_VALID/WREQ_ADDR/WREQ_DATA, RREQ_VALID/RREQ_ADDR[/RREQ_LEN], RDDATA
//     out WREQ_READY, RREQ_READY, RRSP_VALID/RRSP_DATA, CS_N/WR_N/WRADDR/RDADDR/WRDATA
//   slave modport  : view of the clients and the SRAM (directions reversed)
//   RREQ_LEN exists only when SRAM_PORT_MASTER_BURST_EN is defined.
interface sram_port_master_if
  import sram_port_master_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) ();

  logic              WREQ_VALID;
  logic              WREQ_READY;
  logic [ADDR_W-1:0] WREQ_ADDR;
  logic [DATA_W-1:0] WREQ_DATA;
  logic              RREQ_VALID;
  logic              RREQ_READY;
  logic [ADDR_W-1:0] RREQ_ADDR;
`ifdef SRAM_PORT_MASTER_BURST_EN
  logic [7:0]        RREQ_LEN;
`endif
  logic              RRSP_VALID;
  logic [DATA_W-1:0] RRSP_DATA;
  logic              CS_N;
  logic              WR_N;
  logic [ADDR_W-1:0] WRADDR;
  logic [ADDR_W-1:0] RDADDR;
  logic [DATA_W-1:0] WRDATA;
  logic [DATA_W-1:0] RDDATA;

  modport master (
`ifdef SRAM_PORT_MASTER_BURST_EN
    input  RREQ_LEN,
`endif
    input  WREQ_VALID, WREQ_ADDR, WREQ_DATA,
    input  RREQ_VALID, RREQ_ADDR,
    input  RDDATA,
    output WREQ_READY, RREQ_READY,
    output RRSP_VALID, RRSP_DATA,
    output CS_N, WR_N, WRADDR, RDADDR, WRDATA
  );

  modport slave (
`ifdef SRAM_PORT_MASTER_BURST_EN
    output RREQ_LEN,
`endif
    output WREQ_VALID, WREQ_ADDR, WREQ_DATA,
    output RREQ_VALID, RREQ_ADDR,
    output RDDATA,
    input  WREQ_READY, RREQ_READY,
    input  RRSP_VALID, RRSP_DATA,
    input  CS_N, WR_N, WRADDR, RDADDR, WRDATA
  );

endinterface

// File: rtl/sram_rr_arb.sv
// sram_rr_arb
//   Two-requester round-robin arbiter (write side vs read side).
//   CLK, RST      : clock, synchronous active-high reset
//   req_w, req_r  : requests from the write and read sides
//   gnt_w, gnt_r  : combinational one-hot (or zero) grants
//   A single requester always wins; on contention the side that was not
//   granted most recently wins. Reset gives the write side priority.
module sram_rr_arb (
  input  logic CLK,
  input  logic RST,
  input  logic req_w,
  input  logic req_r,
  output logic gnt_w,
  output logic gnt_r
);

  // Set when the read side should win the next contended cycle.
  logic prio_rd;

  assign gnt_w = req_w && (!req_r || !prio_rd);
  assign gnt_r = req_r && (!req_w ||  prio_rd);

  // Priority moves only when something is actually granted.
  always_ff @(posedge CLK) begin
    if (RST) begin
      prio_rd <= 1'b0;
    end else if (gnt_w) begin
      prio_rd <= 1'b1;
    end else if (gnt_r) begin
      prio_rd <= 1'b0;
    end
  end

endmodule

// File: rtl/sram_port_master.sv
// sram_port_master
//   Merges a pixel-write stream and a display-read stream onto a single-port
//   1K x 16 synchronous SRAM, at most one SRAM operation per cycle, and
//   returns read data with a valid strobe two cycles after acceptance.
//   CLK  : system clock, rising edge
//   RST  : synchronous active-high reset
//   bus  : sram_port_master_if.master (request streams, read response, SRAM pins)
//   Optional feature macro SRAM_PORT_MASTER_BURST_EN: adds RREQ_LEN; one read
//   request then issues RREQ_LEN+1 sequential reads with address wrap.
module sram_port_master
  import sram_port_master_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                 CLK,
  input  logic                 RST,
  sram_port_master_if.master   bus
);

  logic              req_r;
  logic              gnt_w;
  logic              gnt_r;
  logic [ADDR_W-1:0] rd_addr;
  op_e               op;
  logic [READ_LAT-1:0] rd_pend;

  sram_rr_arb u_arb (
    .CLK   (CLK),
    .RST   (RST),
    .req_w (bus.WREQ_VALID),
    .req_r (req_r),
    .gnt_w (gnt_w),
    .gnt_r (gnt_r)
  );

  assign bus.WREQ_READY = gnt_w;

`ifdef SRAM_PORT_MASTER_BURST_EN
  logic [0:0]        rd_state;
  logic [ADDR_W-1:0] burst_addr;
  logic [7:0]        beats_left;

  // During a burst the read side keeps requesting on its own and the
  // request port is closed; otherwise the client request passes through.
  always_comb begin
    req_r          = bus.RREQ_VALID;
    rd_addr        = bus.RREQ_ADDR;
    bus.RREQ_READY = gnt_r;
    if (rd_state == RD_BURST) begin
      req_r          = 1'b1;
      rd_addr        = burst_addr;
      bus.RREQ_READY = 1'b0;
    end
  end

  // The accepting grant issues beat 0; beats_left counts the beats still owed.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_state   <= RD_IDLE;
      burst_addr <= '0;
      beats_left <= '0;
    end else begin
      case (rd_state)
        RD_IDLE: begin
          if (gnt_r && (bus.RREQ_LEN != 8'd0)) begin
            rd_state   <= RD_BURST;
            burst_addr <= bus.RREQ_ADDR + ADDR_W'(1);
            beats_left <= bus.RREQ_LEN;
          end
        end
        default: begin
          if (gnt_r) begin
            burst_addr <= burst_addr + ADDR_W'(1);
            beats_left <= beats_left - 8'd1;
            if (beats_left == 8'd1) begin
              rd_state <= RD_IDLE;
            end
          end
        end
      endcase
    end
  end
`else
  assign req_r          = bus.RREQ_VALID;
  assign rd_addr        = bus.RREQ_ADDR;
  assign bus.RREQ_READY = gnt_r;
`endif

  always_comb begin
    op = OP_IDLE;
    if (gnt_w) begin
      op = OP_WR;
    end else if (gnt_r) begin
      op = OP_RD;
    end
  end

  // SRAM pins are registered; addresses and write data hold when idle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      bus.CS_N   <= 1'b1;
      bus.WR_N   <= 1'b1;
      bus.WRADDR <= '0;
      bus.RDADDR <= '0;
      bus.WRDATA <= '0;
    end else begin
      case (op)
        OP_WR: begin
          bus.CS_N   <= 1'b0;
          bus.WR_N   <= 1'b0;
          bus.WRADDR <= bus.WREQ_ADDR;
          bus.WRDATA <= bus.WREQ_DATA;
        end
        OP_RD: begin
          bus.CS_N   <= 1'b0;
          bus.WR_N   <= 1'b1;
          bus.RDADDR <= rd_addr;
        end
        default: begin
          bus.CS_N <= 1'b1;
          bus.WR_N <= 1'b1;
        end
      endcase
    end
  end

  // Stage 0 marks the cycle the read is on the pins, stage 1 the cycle the
  // SRAM's registered data is on RDDATA. Reset drops anything in flight.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_pend <= '0;
    end else begin
      rd_pend <= {rd_pend[READ_LAT-2:0], (op == OP_RD)};
    end
  end

  assign bus.RRSP_VALID = rd_pend[READ_LAT-1];
  assign bus.RRSP_DATA  = rd_pend[READ_LAT-1] ? bus.RDDATA : '0;

endmodule

// File: tb/tb_sram_port_master.sv
// tb_sram_port_master
//   Directed bench for sram_port_master with a behavioural 1K x 16 SRAM
//   (registered read, returns 0 when not reading, preloaded with 0x8000|addr).
module tb_sram_port_master;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   pulses;

  always #5 CLK = ~CLK;

  sram_port_master_if bus ();

  sram_port_master dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  logic [15:0] mem [0:1023];

  initial begin
    for (int a = 0; a < 1024; a++) mem[a] = 16'h8000 | 16'(a);
    bus.RDDATA = '0;
    forever begin
      @(posedge CLK);
      if (!bus.CS_N && !bus.WR_N) mem[bus.WRADDR] <= bus.WRDATA;
      if (!bus.CS_N && bus.WR_N) bus.RDDATA <= mem[bus.RDADDR];
      else bus.RDDATA <= '0;
    end
  end

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic applyStimulus(input logic wv, input logic [9:0] wa, input logic [15:0] wd,
                               input logic rv, input logic [9:0] ra);
    bus.WREQ_VALID = wv;
    bus.WREQ_ADDR  = wa;
    bus.WREQ_DATA  = wd;
    bus.RREQ_VALID = rv;
    bus.RREQ_ADDR  = ra;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_cs_n"},   32'(bus.CS_N),       32'd1);
    checkOutput({tag, "_wr_n"},   32'(bus.WR_N),       32'd1);
    checkOutput({tag, "_wraddr"}, 32'(bus.WRADDR),     32'd0);
    checkOutput({tag, "_rdaddr"}, 32'(bus.RDADDR),     32'd0);
    checkOutput({tag, "_wrdata"}, 32'(bus.WRDATA),     32'd0);
    checkOutput({tag, "_rvalid"}, 32'(bus.RRSP_VALID), 32'd0);
    checkOutput({tag, "_rdata"},  32'(bus.RRSP_DATA),  32'd0);
  endtask

  initial begin
`ifdef SRAM_PORT_MASTER_BURST_EN
    logic [9:0]  exp_addr [4];
    logic [15:0] exp_data [4];
    bus.RREQ_LEN = 8'd0;
`endif
    $display("[TB] start");
    applyStimulus(1'b0, 10'h0, 16'h0, 1'b0, 10'h0);
    tick();
    tick();
    checkResetValues("reset");
    RST = 1'b0;

    // Write 0x005=0xBEEF, read it back the following cycle.
    applyStimulus(1'b1, 10'h005, 16'hBEEF, 1'b0, 10'h0);
    checkOutput("t1_wready", 32'(bus.WREQ_READY), 32'd1);
    checkOutput("t1_rready_idle", 32'(bus.RREQ_READY), 32'd0);
    tick();
    checkOutput("t1_w_cs_n", 32'(bus.CS_N), 32'd0);
    checkOutput("t1_w_wr_n", 32'(bus.WR_N), 32'd0);
    checkOutput("t1_wraddr", 32'(bus.WRADDR), 32'h005);
    checkOutput("t1_wrdata", 32'(bus.WRDATA), 32'hBEEF);
    applyStimulus(1'b0, 10'h005, 16'hBEEF, 1'b1, 10'h005);
    checkOutput("t1_rready", 32'(bus.RREQ_READY), 32'd1);
    tick();
    checkOutput("t1_r_cs_n", 32'(bus.CS_N), 32'd0);
    checkOutput("t1_r_wr_n", 32'(bus.WR_N), 32'd1);
    checkOutput("t1_rdaddr", 32'(bus.RDADDR), 32'h005);
    checkOutput("t1_rvalid_early", 32'(bus.RRSP_VALID), 32'd0);
    applyStimulus(1'b0, 10'h0, 16'h0, 1'b0, 10'h0);
    tick();
    checkOutput("t1_rvalid", 32'(bus.RRSP_VALID), 32'd1);
    checkOutput("t1_rdata", 32'(bus.RRSP_DATA), 32'hBEEF);
    checkOutput("t1_idle_cs_n", 32'(bus.CS_N), 32'd1);
    tick();
    checkOutput("t1_rvalid_off", 32'(bus.RRSP_VALID), 32'd0);
    checkOutput("t1_rdata_off", 32'(bus.RRSP_DATA), 32'd0);
    checkOutput("t1_wraddr_hold", 32'(bus.WRADDR), 32'h005);
    checkOutput("t1_rdaddr_hold", 32'(bus.RDADDR), 32'h005);

    // Contention after reset: W,R,W,R,W,R.
    RST = 1'b1;
    tick();
    RST = 1'b0;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      if (i < 6) begin
        applyStimulus(1'b1, 10'(32'h20 + (i + 1) / 2), 16'(32'hA000 + (i + 1) / 2),
                      1'b1, 10'(32'h20 + i / 2));
        checkOutput("rr_wready", 32'(bus.WREQ_READY), 32'(i % 2 == 0));
        checkOutput("rr_rready", 32'(bus.RREQ_READY), 32'(i % 2 == 1));
      end else begin
        applyStimulus(1'b0, 10'h0, 16'h0, 1'b0, 10'h0);
      end
      tick();
      if (bus.RRSP_VALID) pulses++;
      if (i == 2 || i == 4 || i == 6)
        checkOutput("rr_rdata", 32'(bus.RRSP_DATA), 32'hA000 + 32'(i / 2 - 1));
    end
    checkOutput("rr_pulses", 32'(pulses), 32'd3);

    // Back-to-back reads at the address extremes.
    applyStimulus(1'b1, 10'h3FF, 16'h5A5A, 1'b0, 10'h0);
    tick();
    applyStimulus(1'b1, 10'h000, 16'hC3C3, 1'b0, 10'h0);
    tick();
    applyStimulus(1'b0, 10'h0, 16'h0, 1'b1, 10'h3FF);
    tick();
    checkOutput("b2b_rdaddr0", 32'(bus.RDADDR), 32'h3FF);
    applyStimulus(1'b0, 10'h0, 16'h0, 1'b1, 10'h000);
    tick();
    checkOutput("b2b_rdaddr1", 32'(bus.RDADDR), 32'h000);
    checkOutput("b2b_rvalid0", 32'(bus.RRSP_VALID), 32'd1);
    checkOutput("b2b_rdata0", 32'(bus.RRSP_DATA), 32'h5A5A);
    applyStimulus(1'b0, 10'h0, 16'h0, 1'b0, 10'h0);
    tick();
    checkOutput("b2b_rvalid1", 32'(bus.RRSP_VALID), 32'd1);
    checkOutput("b2b_rdata1", 32'(bus.RRSP_DATA), 32'hC3C3);
    checkOutput("b2b_idle_cs_n", 32'(bus.CS_N), 32'd1);
    tick();
    checkOutput("b2b_rvalid_off", 32'(bus.RRSP_VALID), 32'd0);
    checkOutput("b2b_rdata_off", 32'(bus.RRSP_DATA), 32'd0);
    checkOutput("b2b_idle_cs_n2", 32'(bus.CS_N), 32'd1);

    // Reset right after a read accept kills the response.
    applyStimulus(1'b0, 10'h0, 16'h0, 1'b1, 10'h3FF);
    tick();
    applyStimulus(1'b0, 10'h0, 16'h0, 1'b0, 10'h0);
    RST = 1'b1;
    tick();
    checkResetValues("midrst");
    RST = 1'b0;
    tick();
    checkOutput("midrst_rvalid_after", 32'(bus.RRSP_VALID), 32'd0);
    checkOutput("midrst_rdata_after", 32'(bus.RRSP_DATA), 32'd0);

    // Reset restores write priority even after a write grant.
    applyStimulus(1'b1, 10'h050, 16'h1234, 1'b0, 10'h0);
    tick();
    RST = 1'b1;
    applyStimulus(1'b0, 10'h0, 16'h0, 1'b0, 10'h0);
    tick();
    RST = 1'b0;
    applyStimulus(1'b1, 10'h051, 16'h4321, 1'b1, 10'h051);
    checkOutput("prio_wready", 32'(bus.WREQ_READY), 32'd1);
    checkOutput("prio_rready", 32'(bus.RREQ_READY), 32'd0);
    tick();
    checkOutput("prio_wr_n", 32'(bus.WR_N), 32'd0);
    applyStimulus(1'b0, 10'h0, 16'h0, 1'b0, 10'h0);
    tick();
    tick();
    tick();

`ifdef SRAM_PORT_MASTER_BURST_EN
    // Burst of 4 across the wrap point.
    exp_addr = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
    exp_data = '{16'h83FE, 16'h5A5A, 16'hC3C3, 16'h8001};
    pulses = 0;
    bus.RREQ_LEN = 8'd3;
    applyStimulus(1'b0, 10'h0, 16'h0, 1'b1, 10'h3FE);
    checkOutput("burst_accept", 32'(bus.RREQ_READY), 32'd1);
    for (int b = 0; b < 4; b++) begin
      if (b > 0) begin
        bus.RREQ_LEN = 8'd0;
        applyStimulus(1'b0, 10'h0, 16'h0, (b < 3), 10'h123);
        checkOutput("burst_ready_low", 32'(bus.RREQ_READY), 32'd0);
      end
      tick();
      checkOutput("burst_rdaddr", 32'(bus.RDADDR), 32'(exp_addr[b]));
      checkOutput("burst_cs_n", 32'(bus.CS_N), 32'd0);
      if (bus.RRSP_VALID) pulses++;
      if (b > 0) checkOutput("burst_rdata", 32'(bus.RRSP_DATA), 32'(exp_data[b-1]));
    end
    applyStimulus(1'b0, 10'h0, 16'h0, 1'b0, 10'h0);
    tick();
    if (bus.RRSP_VALID) pulses++;
    checkOutput("burst_rdata_last", 32'(bus.RRSP_DATA), 32'(exp_data[3]));
    checkOutput("burst_done_cs_n", 32'(bus.CS_N), 32'd1);
    tick();
    if (bus.RRSP_VALID) pulses++;
    checkOutput("burst_pulses", 32'(pulses), 32'd4);

    // Burst of 3 interleaved with a continuous write stream.
    for (int i = 0; i < 6; i++) begin
      bus.RREQ_LEN = (i <= 1) ? 8'd2 : 8'd0;
      applyStimulus(1'b1, 10'(32'h100 + (i + 1) / 2), 16'(32'h7700 + (i + 1) / 2),
                    (i <= 1), 10'h200);
      checkOutput("mix_rready", 32'(bus.RREQ_READY), 32'(i == 1));
      checkOutput("mix_wready", 32'(bus.WREQ_READY), 32'(i % 2 == 0));
      tick();
      checkOutput("mix_cs_n", 32'(bus.CS_N), 32'd0);
      checkOutput("mix_wr_n", 32'(bus.WR_N), 32'(i % 2));
      if (i % 2 == 1) checkOutput("mix_rdaddr", 32'(bus.RDADDR), 32'h200 + 32'(i / 2));
      else checkOutput("mix_wraddr", 32'(bus.WRADDR), 32'h100 + 32'(i / 2));
    end
    bus.RREQ_LEN = 8'd0;
    applyStimulus(1'b0, 10'h0, 16'h0, 1'b1, 10'h300);
    checkOutput("mix_idle_again", 32'(bus.RREQ_READY), 32'd1);
    tick();
    applyStimulus(1'b0, 10'h0, 16'h0, 1'b0, 10'h0);
    tick();
    tick();
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
